wbi_burst_arb: RTL and testbench

WBI_BURST_ARB -- requirements
Module: wbi_burst_arb

---
 rtl/wbi_burst_arb.sv | 131 +++++++++++++
 tb/tb_wbi_burst_arb.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/wbi_burst_arb.sv
// wbi_burst_arb: round-robin burst arbiter for N command requesters.
// A winner is chosen in IDLE and holds the grant for a whole burst of
// bl beats (bl==0 treated as 1). The grant is released on the last beat
// or when the granted requester drops its request (abort). Every release
// is followed by one IDLE cycle before the next grant.
//
// Ports:
//   mclk        clock, rising edge
//   reset_n     synchronous active-low reset
//   req_i       per-requester command valid
//   bl_i        per-requester burst count, slice k = bl_i[k*BL +: BL]
//   rdy_i       downstream ready
//   gnt_o       one-hot grant (registered)
//   gnt_id_o    binary grant index (registered)
//   gnt_val_o   grant held, state BURST (registered)
//   beat_o      beat accepted this cycle
//   last_o      accepted beat is the last of the burst
//   abort_o     granted requester dropped its request mid-burst
//   beat_cnt_o  beats remaining including the current one (registered)
module wbi_burst_arb #(
    parameter int N  = 4,
    parameter int BL = 10,
    parameter int IW = $clog2(N)
) (
    input  logic            mclk,
    input  logic            reset_n,
    input  logic [N-1:0]    req_i,
    input  logic [N*BL-1:0] bl_i,
    input  logic            rdy_i,
    output logic [N-1:0]    gnt_o,
    output logic [IW-1:0]   gnt_id_o,
    output logic            gnt_val_o,
    output logic            beat_o,
    output logic            last_o,
    output logic            abort_o,
    output logic [BL-1:0]   beat_cnt_o
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [IW-1:0]   gnt_id_q, gnt_id_d;
    logic [BL-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   ptr_q, ptr_d;

    logic            win_found;
    logic [IW-1:0]   win_id;
    logic [IW-1:0]   idx;
    logic [BL-1:0]   win_bl;
    logic            req_cur;

    // Round-robin search: first requester at or after ptr+1, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        idx       = '0;
        for (int i = 0; i < N; i++) begin
            idx = IW'((int'(ptr_q) + 1 + i) % N);
            if (!win_found && req_i[idx]) begin
                win_found = 1'b1;
                win_id    = idx;
            end
        end
    end

    assign win_bl  = bl_i[int'(win_id)*BL +: BL];
    assign req_cur = req_i[gnt_id_q];

    assign gnt_o      = gnt_q;
    assign gnt_id_o   = gnt_id_q;
    assign gnt_val_o  = (state_q == BURST);
    assign beat_cnt_o = cnt_q;

    // Gated by reset_n so a reset landing mid-burst produces no beat,
    // last or abort in the cycle it is asserted.
    assign beat_o  = gnt_val_o & req_cur & rdy_i & reset_n;
    assign last_o  = beat_o & (cnt_q == BL'(1));
    assign abort_o = gnt_val_o & ~req_cur & reset_n;

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        gnt_id_d = gnt_id_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d  = BURST;
                    gnt_d    = N'(1) << win_id;
                    gnt_id_d = win_id;
                    cnt_d    = (win_bl == '0) ? BL'(1) : win_bl;
                end
            end
            BURST: begin
                if (!req_cur) begin
                    // Abort: release without consuming a beat.
                    state_d = IDLE;
                    gnt_d   = '0;
                    ptr_d   = gnt_id_q;
                end else if (beat_o) begin
                    cnt_d = cnt_q - BL'(1);
                    if (cnt_q == BL'(1)) begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        ptr_d   = gnt_id_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge mclk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            cnt_q    <= '0;
            ptr_q    <= IW'(N - 1);
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
        end
    end

endmodule

// File: tb/tb_wbi_burst_arb.sv
// Scoreboard bench for wbi_burst_arb. Stimulus pushes one expected record
// per BURST cycle (cycle number, grant, count, beat/last/abort); the monitor
// pops a record on every cycle with gnt_val_o=1 and checks idle cycles
// for a clean bus.
module tb_wbi_burst_arb;
    localparam int N  = 4;
    localparam int BL = 10;
    localparam int IW = 2;

    logic            mclk = 1'b0;
    logic            reset_n;
    logic [N-1:0]    req_i;
    logic [N*BL-1:0] bl_i;
    logic            rdy_i;
    logic [N-1:0]    gnt_o;
    logic [IW-1:0]   gnt_id_o;
    logic            gnt_val_o, beat_o, last_o, abort_o;
    logic [BL-1:0]   beat_cnt_o;

    wbi_burst_arb #(.N(N), .BL(BL), .IW(IW)) dut (
        .mclk(mclk), .reset_n(reset_n), .req_i(req_i), .bl_i(bl_i),
        .rdy_i(rdy_i), .gnt_o(gnt_o), .gnt_id_o(gnt_id_o),
        .gnt_val_o(gnt_val_o), .beat_o(beat_o), .last_o(last_o),
        .abort_o(abort_o), .beat_cnt_o(beat_cnt_o)
    );

    always #5 mclk = ~mclk;

    int cyc = 0;
    always @(posedge mclk) cyc <= cyc + 1;

    typedef struct {
        int c; int id; int cnt; bit beat; bit last; bit abort;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_en = 1'b0;

    task automatic push(input int c, input int id, input int cnt,
                        input bit beat, input bit last, input bit abort);
        exp_t e;
        e.c = c; e.id = id; e.cnt = cnt;
        e.beat = beat; e.last = last; e.abort = abort;
        q.push_back(e);
    endtask

    // Uninterrupted burst of n beats starting at cycle c.
    task automatic burst(input int c, input int id, input int n);
        for (int k = 0; k < n; k++)
            push(c + k, id, n - k, 1'b1, (k == n - 1), 1'b0);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge mclk);
        #1;
    endtask

    task automatic set_bl(input int k, input int v);
        bl_i[k*BL +: BL] = BL'(v);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor
    exp_t        me;
    logic [N-1:0] eg;
    always @(negedge mclk) begin
        if (mon_en) begin
            if (gnt_val_o) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_grant: cyc=%0d id=%0d cnt=%0d", cyc, gnt_id_o, beat_cnt_o);
                end else begin
                    me = q.pop_front();
                    eg = N'(1) << me.id;
                    if (cyc != me.c || gnt_o != eg || int'(gnt_id_o) != me.id ||
                        int'(beat_cnt_o) != me.cnt || beat_o != me.beat ||
                        last_o != me.last || abort_o != me.abort) begin
                        n_bad++;
                        $display("FAIL sb_record: got cyc=%0d gnt=%b id=%0d cnt=%0d b/l/a=%b%b%b expected cyc=%0d gnt=%b id=%0d cnt=%0d b/l/a=%b%b%b",
                                 cyc, gnt_o, gnt_id_o, beat_cnt_o, beat_o, last_o, abort_o,
                                 me.c, eg, me.id, me.cnt, me.beat, me.last, me.abort);
                    end
                end
            end else begin
                n_cmp++;
                if (gnt_o != '0 || beat_o || last_o || abort_o) begin
                    n_bad++;
                    $display("FAIL idle_quiet: cyc=%0d gnt=%b b/l/a=%b%b%b expected gnt=0 b/l/a=000",
                             cyc, gnt_o, beat_o, last_o, abort_o);
                end
            end
        end
    end

    int c0;
    int rr_ord[5] = '{0, 1, 2, 3, 0};

    initial begin
        reset_n = 1'b0;
        req_i   = '0;
        bl_i    = '0;
        rdy_i   = 1'b1;
        tick(2);
        check("rst_gnt",     int'(gnt_o), 0);
        check("rst_gnt_id",  int'(gnt_id_o), 0);
        check("rst_gnt_val", int'(gnt_val_o), 0);
        check("rst_cnt",     int'(beat_cnt_o), 0);
        check("rst_abort",   int'(abort_o), 0);
        check("rst_beat",    int'(beat_o), 0);
        check("rst_last",    int'(last_o), 0);
        reset_n = 1'b1;
        mon_en  = 1'b1;

        // Round robin from reset: 0,1,2,3,0 with one idle cycle between.
        for (int k = 0; k < N; k++) set_bl(k, 1);
        req_i = 4'b1111;
        c0 = cyc;
        for (int g = 0; g < 5; g++) burst(c0 + 1 + 2*g, rr_ord[g], 1);
        tick(10);
        req_i = '0;
        tick(2);

        // Single request, bl=3 (pointer at 0 -> requester 2 wins).
        set_bl(2, 3);
        req_i = 4'b0100;
        c0 = cyc;
        burst(c0 + 1, 2, 3);
        tick(4);
        req_i = '0;
        tick(2);

        // Stall: bl=2, rdy 1,0,0,0,1.
        set_bl(3, 2);
        req_i = 4'b1000;
        c0 = cyc;
        push(c0 + 1, 3, 2, 1'b1, 1'b0, 1'b0);
        push(c0 + 2, 3, 1, 1'b0, 1'b0, 1'b0);
        push(c0 + 3, 3, 1, 1'b0, 1'b0, 1'b0);
        push(c0 + 4, 3, 1, 1'b0, 1'b0, 1'b0);
        push(c0 + 5, 3, 1, 1'b1, 1'b1, 1'b0);
        tick(2);
        rdy_i = 1'b0;
        tick(3);
        rdy_i = 1'b1;
        tick(1);
        req_i = '0;
        tick(2);

        // Abort: requester 1, bl=4, drops after 2 beats; next search from 2.
        set_bl(1, 4);
        req_i = 4'b0010;
        c0 = cyc;
        push(c0 + 1, 1, 4, 1'b1, 1'b0, 1'b0);
        push(c0 + 2, 1, 3, 1'b1, 1'b0, 1'b0);
        push(c0 + 3, 1, 2, 1'b0, 1'b0, 1'b1);
        tick(3);
        req_i = '0;
        tick(1);
        for (int k = 0; k < N; k++) set_bl(k, 1);
        req_i = 4'b1111;
        push(c0 + 5, 2, 1, 1'b1, 1'b1, 1'b0);
        tick(2);
        req_i = '0;
        tick(2);

        // bl=0 counts as one beat; persistent single requester is re-granted.
        set_bl(0, 0);
        req_i = 4'b0001;
        c0 = cyc;
        push(c0 + 1, 0, 1, 1'b1, 1'b1, 1'b0);
        push(c0 + 3, 0, 1, 1'b1, 1'b1, 1'b0);
        tick(4);
        req_i = '0;
        tick(2);

        // Reset mid-burst after 1 of 4 beats.
        set_bl(2, 4);
        req_i = 4'b0100;
        c0 = cyc;
        push(c0 + 1, 2, 4, 1'b1, 1'b0, 1'b0);
        push(c0 + 2, 2, 3, 1'b0, 1'b0, 1'b0);
        tick(2);
        reset_n = 1'b0;
        tick(1);
        check("midrst_gnt",     int'(gnt_o), 0);
        check("midrst_cnt",     int'(beat_cnt_o), 0);
        check("midrst_gnt_val", int'(gnt_val_o), 0);
        set_bl(3, 1);
        req_i   = 4'b1000;
        reset_n = 1'b1;
        push(c0 + 4, 3, 1, 1'b1, 1'b1, 1'b0);
        tick(2);
        req_i = '0;
        tick(3);

        check("sb_drain", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
